// File: rtl/axi_slave_read_responder.sv
// AXI slave read responder: one outstanding AR, 1-cycle-latency SRAM fetch per beat, R burst with RLAST.
// Define AXI_RD_RANGE_CHK_EN to return DECERR (no SRAM access) for beats at word addresses >= MEM_WORDS.
module axi_slave_read_responder #(
    parameter int unsigned ID_W      = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_AW    = 14,
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              mem_ce,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, CAPT, RESP} state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [3:0]          len_q;
    logic [3:0]          beat_q;
    logic [1:0]          burst_q;
    logic                arready_q;
    logic                rvalid_q;
    logic                rlast_q;
    logic [ID_W-1:0]     rid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic [MEM_AW-1:0]   mem_addr_q;
    logic [MEM_AW-1:0]   addr_nxt;
    logic                ar_hs;
    logic                r_hs;
    logic                oor;
    logic                unused_ok;

    assign ar_hs = ARVALID && arready_q && (state_q == IDLE);
    assign r_hs  = rvalid_q && RREADY;

`ifdef AXI_RD_RANGE_CHK_EN
    assign oor       = ({{(32-MEM_AW){1'b0}}, addr_q} >= MEM_WORDS);
    assign unused_ok = ^{ARSIZE, ARADDR};
`else
    assign oor       = 1'b0;
    assign unused_ok = ^{ARSIZE, ARADDR, MEM_WORDS};
`endif

    // WRAP keeps the high bits and wraps the low log2(len+1) bits; non power-of-two lengths fall back to INCR.
    function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a,
                                                     input logic [3:0]        len,
                                                     input logic [1:0]        burst);
        logic [MEM_AW-1:0] mask;
        logic [MEM_AW-1:0] inc;
        mask = MEM_AW'(len);
        inc  = a + 1'b1;
        if (burst == BURST_FIXED) begin
            next_addr = a;
        end else if ((burst == BURST_WRAP) && (len != 4'd0) && ((len & (len + 4'd1)) == 4'd0)) begin
            next_addr = (a & ~mask) | (inc & mask);
        end else begin
            next_addr = inc;
        end
    endfunction

    assign addr_nxt = next_addr(addr_q, len_q, burst_q);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    state_d = (ARBURST == BURST_RSVD) ? RESP : FETCH;
                end
            end
            FETCH: state_d = CAPT;
            CAPT:  state_d = RESP;
            RESP: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else if (burst_q == BURST_RSVD) begin
                        state_d = RESP;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_ce = 1'b0;
        if ((state_q == FETCH) && !oor) begin
            mem_ce = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            mem_addr_q <= '0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            burst_q    <= '0;
        end else begin
            arready_q <= (state_d == IDLE);
            rvalid_q  <= (state_d == RESP);
            if (ar_hs) begin
                id_q    <= ARID;
                addr_q  <= ARADDR[MEM_AW+1:2];
                len_q   <= ARLEN;
                burst_q <= ARBURST;
                beat_q  <= '0;
                if (ARBURST == BURST_RSVD) begin
                    rid_q   <= ARID;
                    rdata_q <= '0;
                    rresp_q <= RESP_DECERR;
                    rlast_q <= (ARLEN == 4'd0);
                end else begin
                    mem_addr_q <= ARADDR[MEM_AW+1:2];
                end
            end
            if (state_q == CAPT) begin
                rid_q   <= id_q;
                rdata_q <= oor ? '0 : mem_rdata;
                rresp_q <= oor ? RESP_DECERR : RESP_OKAY;
                rlast_q <= (beat_q == len_q);
            end
            if (r_hs && !rlast_q) begin
                beat_q <= beat_q + 4'd1;
                addr_q <= addr_nxt;
                if (burst_q == BURST_RSVD) begin
                    rlast_q <= ((beat_q + 4'd1) == len_q);
                end else begin
                    mem_addr_q <= addr_nxt;
                end
            end
        end
    end

    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RLAST    = rlast_q;
    assign RID      = rid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_axi_slave_read_responder.sv
// Self-checking bench for axi_slave_read_responder: directed and randomized bursts against an
// arithmetic burst/address model, with an SRAM model that logs every mem_ce access.
module tb_axi_slave_read_responder;

`ifdef AXI_RD_RANGE_CHK_EN
    localparam int unsigned MEM_WORDS_TB = 16;
    localparam bit          RANGE_EN     = 1'b1;
`else
    localparam int unsigned MEM_WORDS_TB = 16384;
    localparam bit          RANGE_EN     = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [7:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [3:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = 3'b010;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        mem_ce;
    logic [13:0] mem_addr;
    logic [31:0] mem_rdata;

    logic [31:0] sram [0:16383];
    int unsigned ce_log [$];
    int errors = 0;
    int checks = 0;

    axi_slave_read_responder #(
        .ID_W(8), .DATA_W(32), .ADDR_W(32), .MEM_AW(14), .MEM_WORDS(MEM_WORDS_TB)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (mem_ce === 1'b1) begin
            mem_rdata <= sram[mem_addr];
            ce_log.push_back(int'(mem_addr));
        end
    end

    // Word address of beat i, from the AXI burst rules.
    function automatic int unsigned exp_addr(input int unsigned start, input int unsigned len,
                                             input int unsigned burst, input int unsigned i);
        int unsigned n;
        int unsigned base;
        n = len + 1;
        if (burst == 0) return start;
        if (burst == 2 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
            base = (start / n) * n;
            return base + ((start - base + i) % n);
        end
        return (start + i) % 16384;
    endfunction

    function automatic bit out_of_range(input int unsigned a);
        return RANGE_EN && (a >= MEM_WORDS_TB);
    endfunction

    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input int mode, input bit junk, input string tag);
        int unsigned start, a, beat, cyc, last_hs, t;
        int unsigned exp_ce [$];
        logic [31:0] e_data, h_data;
        logic [7:0]  h_id;
        logic [1:0]  e_resp, h_resp;
        logic        h_last, rr;
        bit          seen, stalled, ce_bad;
        start = (addr >> 2) & 32'h3FFF;
        for (int unsigned i = 0; i <= len; i++) begin
            a = exp_addr(start, len, burst, i);
            if (burst != 2'b11 && !out_of_range(a)) exp_ce.push_back(a);
        end
        t = 0;
        while (ARREADY !== 1'b1 && t < 50) begin
            @(negedge ACLK);
            t++;
        end
        checks++;
        if (ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL %s arready_wait: ARREADY=%b expected 1", tag, ARREADY);
            return;
        end
        ce_log.delete();
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        RREADY = (mode == 0);
        @(negedge ACLK);
        ARVALID = 1'b0;
        beat = 0; cyc = 1; last_hs = 0; seen = 0; stalled = 0;
        h_data = '0; h_id = '0; h_resp = '0; h_last = 1'b0;
        while (beat <= len && cyc < 400) begin
            checks++;
            if (ARREADY !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_arready: ARREADY=%b expected 0 (beat %0d)", tag, ARREADY, beat);
            end
            if (junk) begin
                ARVALID = 1'($urandom % 2); ARID = 8'($urandom); ARADDR = $urandom;
                ARLEN = 4'($urandom); ARBURST = 2'($urandom);
            end
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((cyc / 2) % 2) : 1'($urandom % 2);
            RREADY = rr;
            if (RVALID === 1'b1) begin
                if (!seen) begin
                    seen = 1;
                    if (burst != 2'b11) begin
                        checks++;
                        if (cyc - last_hs != 3) begin
                            errors++;
                            $display("FAIL %s latency: got %0d cycles expected 3 (beat %0d)", tag, cyc - last_hs, beat);
                        end
                    end
                end
                if (stalled) begin
                    checks++;
                    if ({RDATA, RID, RRESP, RLAST} !== {h_data, h_id, h_resp, h_last}) begin
                        errors++;
                        $display("FAIL %s hold: RDATA=%h RID=%h RRESP=%b RLAST=%b expected %h %h %b %b",
                                 tag, RDATA, RID, RRESP, RLAST, h_data, h_id, h_resp, h_last);
                    end
                end
                if (rr) begin
                    a = exp_addr(start, len, burst, beat);
                    if (burst == 2'b11 || out_of_range(a)) begin
                        e_data = '0; e_resp = 2'b11;
                    end else begin
                        e_data = sram[a]; e_resp = 2'b00;
                    end
                    checks++;
                    if (RDATA !== e_data || RID !== id || RRESP !== e_resp || RLAST !== (beat == len)) begin
                        errors++;
                        $display("FAIL %s beat%0d: RDATA=%h RID=%h RRESP=%b RLAST=%b expected %h %h %b %b",
                                 tag, beat, RDATA, RID, RRESP, RLAST, e_data, id, e_resp, (beat == len));
                    end
                    beat++; last_hs = cyc; seen = 0; stalled = 0;
                end else begin
                    stalled = 1;
                    h_data = RDATA; h_id = RID; h_resp = RRESP; h_last = RLAST;
                end
            end else if (stalled) begin
                checks++;
                errors++;
                $display("FAIL %s rvalid_drop: RVALID=%b expected 1 while stalled", tag, RVALID);
                stalled = 0;
            end
            @(negedge ACLK);
            cyc++;
        end
        ARVALID = 1'b0;
        checks++;
        if (beat <= len) begin
            errors++;
            $display("FAIL %s timeout: beats=%0d expected %0d", tag, beat, len + 1);
            return;
        end
        checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            errors++;
            $display("FAIL %s post_burst: ARREADY=%b RVALID=%b expected 1 0", tag, ARREADY, RVALID);
        end
        ce_bad = (ce_log.size() != exp_ce.size());
        if (!ce_bad) begin
            foreach (exp_ce[i]) if (ce_log[i] != exp_ce[i]) ce_bad = 1;
        end
        checks++;
        if (ce_bad) begin
            errors++;
            $display("FAIL %s mem_access: got %0d accesses %p expected %0d %p",
                     tag, ce_log.size(), ce_log, exp_ce.size(), exp_ce);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ARREADY, RVALID, RLAST, RID, RDATA, RRESP, mem_ce, mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_values: ARREADY=%b RVALID=%b RLAST=%b RID=%h RDATA=%h RRESP=%b mem_ce=%b mem_addr=%h expected all 0",
                     ARREADY, RVALID, RLAST, RID, RDATA, RRESP, mem_ce, mem_addr);
        end
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        checks++;
        if (ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_arready: ARREADY=%b expected 0", ARREADY);
        end
        @(negedge ACLK);
        checks++;
        if (ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_arready_rise: ARREADY=%b expected 1", ARREADY);
        end
    endtask

    task automatic test_single();
        sram[4] = 32'hDEADBEEF;
        run_burst(8'h25, 32'h10, 4'd0, 2'b01, 0, 1'b0, "single");
    endtask

    task automatic test_incr();
        for (int unsigned i = 0; i < 4; i++) sram[64 + i] = i + 1;
        run_burst(8'h11, 32'h100, 4'd3, 2'b01, 0, 1'b0, "incr");
        run_burst(8'h12, 32'hFFFC, 4'd3, 2'b01, 0, 1'b0, "incr_wrap_top");
    endtask

    task automatic test_wrap();
        run_burst(8'h33, 32'h18, 4'd3, 2'b10, 1, 1'b0, "wrap4_bp");
        run_burst(8'h34, 32'h54, 4'd15, 2'b10, 0, 1'b0, "wrap16");
        run_burst(8'h35, 32'h1C, 4'd2, 2'b10, 0, 1'b0, "wrap_illegal_len");
    endtask

    task automatic test_fixed_reserved();
        run_burst(8'h44, 32'h20, 4'd2, 2'b00, 0, 1'b0, "fixed");
        run_burst(8'h45, 32'h40, 4'd1, 2'b11, 0, 1'b0, "reserved");
        run_burst(8'h46, 32'h80, 4'd3, 2'b11, 2, 1'b0, "reserved_bp");
    endtask

    task automatic test_reset_mid_burst();
        int unsigned hs, t;
        hs = 0; t = 0;
        for (int unsigned i = 0; i < 8; i++) sram[128 + i] = 32'hA0000000 + i;
        while (ARREADY !== 1'b1 && t < 50) begin
            @(negedge ACLK);
            t++;
        end
        ARID = 8'h3C; ARADDR = 32'h200; ARLEN = 4'd7; ARBURST = 2'b01; ARVALID = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        t = 0;
        while (t < 100 && !(hs == 2 && RVALID === 1'b1)) begin
            if (RVALID === 1'b1) hs++;
            @(negedge ACLK);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL midreset_third_beat: handshakes=%0d RVALID=%b expected beat 3 valid", hs, RVALID);
        end
        ARESETn = 1'b0;
        RREADY = 1'b0;
        #1;
        checks++;
        if ({ARREADY, RVALID, RLAST, RID, RDATA, RRESP, mem_ce, mem_addr} !== '0) begin
            errors++;
            $display("FAIL midreset_async: ARREADY=%b RVALID=%b RLAST=%b RID=%h RDATA=%h RRESP=%b mem_ce=%b mem_addr=%h expected all 0",
                     ARREADY, RVALID, RLAST, RID, RDATA, RRESP, mem_ce, mem_addr);
        end
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        RREADY = 1'b1;
        #1;
        checks++;
        if (ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: ARREADY=%b expected 0", ARREADY);
        end
        @(negedge ACLK);
        checks++;
        if (ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL midreset_arready: ARREADY=%b expected 1", ARREADY);
        end
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge ACLK);
            checks++;
            if (RVALID !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_resume: RVALID=%b expected 0 (cycle %0d)", RVALID, i);
            end
        end
        sram[0] = 32'h0BADF00D;
        run_burst(8'h01, 32'h0, 4'd0, 2'b01, 0, 1'b0, "after_reset_read");
    endtask

    task automatic test_back_to_back();
        run_burst(8'h51, 32'h300, 4'd1, 2'b01, 0, 1'b1, "b2b_a");
        run_burst(8'h52, 32'h304, 4'd0, 2'b00, 0, 1'b1, "b2b_b");
        run_burst(8'h53, 32'h308, 4'd7, 2'b10, 0, 1'b1, "b2b_c");
    endtask

    task automatic test_random();
        for (int unsigned n = 0; n < 25; n++) begin
            run_burst(8'($urandom), $urandom & 32'h0000_FFFC, 4'($urandom), 2'($urandom),
                      2, 1'b1, $sformatf("rand%0d", n));
        end
    endtask

`ifdef AXI_RD_RANGE_CHK_EN
    task automatic test_range_check();
        run_burst(8'h66, 32'h38, 4'd3, 2'b01, 0, 1'b0, "range_chk");
    endtask
`endif

    initial begin
        for (int unsigned i = 0; i < 16384; i++) sram[i] = $urandom;
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_fixed_reserved();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
`ifdef AXI_RD_RANGE_CHK_EN
        test_range_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
